unary_gen: RTL
==============

UNARY_GEN -- requirements
Module: unary_gen

Interface
REQ-001 Parameter BITWIDTH, default 8: width of the binary input value and of the internal period counter.
REQ-002 iClk  input  1  sole clock; all state updates on the rising edge.
REQ-003 iRstN  input  1  reset, asynchronous and active-low.
REQ-004 iEn  input  1  stream-advance enable; when low in RUN, the stream freezes.
REQ-005 iClr  input  1  synchronous abort: returns the block to IDLE.
REQ-006 iLoad  input  1  start request; accepted only in IDLE or DONE.
REQ-007 iData  input  BITWIDTH  unsigned binary value to encode; sampled on an accepted iLoad.
REQ-008 oBit  output  1  unary bitstream output.
REQ-009 oBusy  output  1  high while in RUN.
REQ-010 oDone  output  1  one-cycle pulse after the last stream bit.
REQ-011 oCnt  output  BITWIDTH  current stream position (period counter value).

Function
REQ-012 FSM states: IDLE, RUN, DONE.
REQ-013 IDLE: oBit=0, oBusy=0, oDone=0; on iLoad=1, latch iData into the value register, clear the counter to 0, and enter RUN at the next edge.
REQ-014 RUN: oBit = (oCnt < value), combinational from registered state; oBusy=1.
REQ-015 RUN, iEn=1: the counter increments by 1 at the edge; the current oBit is the emitted bit for this cycle.
REQ-016 RUN, iEn=0: counter and value hold; oBit holds; no bit is emitted.
REQ-017 Stream length is exactly 2^BITWIDTH emitted bits (positions 0..2^BITWIDTH-1): the first "value" bits are 1 and the remainder are 0 (thermometer order).
REQ-018 RUN with oCnt = all-ones and iEn=1: the counter wraps to 0 and the next state is DONE.
REQ-019 DONE lasts exactly one cycle: oDone=1, oBit=0, oBusy=0; next state is IDLE, or RUN if iLoad=1 in that cycle (back-to-back streams with no gap bit).
REQ-020 iLoad while in RUN is ignored; the value register is not modified.
REQ-021 iData=0 produces 2^BITWIDTH zeros; iData=all-ones produces 2^BITWIDTH-1 ones followed by a single 0.
REQ-022 iClr=1 in any state: next state is IDLE and the counter is cleared to 0; iClr has priority over iLoad and iEn; no oDone pulse is generated.
REQ-023 oCnt in IDLE and DONE is 0.

Reset
REQ-024 iRstN=0 forces, asynchronously: state=IDLE, counter=0, value register=0, oBit=0, oBusy=0, oDone=0.
REQ-025 Reset deasserted mid-stream: the block remains in IDLE and ignores the aborted stream; the first iLoad after release starts a fresh stream.

Structure
REQ-026 A shared package holds the FSM state enum (IDLE/RUN/DONE) and the default BITWIDTH constant.
REQ-027 The period counter is implemented by instantiating the existing cntwithen module: iEn = RUN && iEn, and iClr = iClr || accepted iLoad.
REQ-028 The comparator and FSM reside in unary_gen; no other sub-modules are used.

Verification
REQ-029 BITWIDTH=8, iLoad with iData=0x40, iEn=1 continuously -> 64 ones, then 192 zeros, then an oDone pulse on the 257th cycle after the cycle of RUN entry.
REQ-030 iData=0x00 and iData=0xFF -> ones count 0 and 255 respectively; each stream lasts 256 emitted bits.
REQ-031 iData=0x80 with iEn toggled at 50% -> 128 ones among the 256 iEn-high cycles, and oCnt frozen during every iEn=0 cycle.
REQ-032 iClr=1 at oCnt=0x10 mid-stream -> IDLE next cycle, oCnt=0, no oDone; a subsequent iLoad with 0x05 yields exactly 5 ones.
REQ-033 iLoad held high through DONE with new iData=0x03 -> the next stream starts without a gap; iLoad pulses during RUN leave the value unchanged.
REQ-034 Round trip: oBit gated by iEn feeds a cntwithen counter; after oDone the counter equals iData, for 16 random values.

Source files
------------

// File: rtl/unary_gen_pkg.sv
// Shared definitions for the unary bitstream generator: FSM states and default width.
// No logic; latency/backpressure defined by the users of these types.
package unary_gen_pkg;

    localparam int DEF_BITWIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/unary_gen_if.sv
// Control and stream signals of the unary generator; master drives requests, slave produces the stream.
// Purely structural; no latency, the generator never stalls the requester.
interface unary_gen_if
    import unary_gen_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH
);
    logic                iEn;
    logic                iClr;
    logic                iLoad;
    logic [BITWIDTH-1:0] iData;
    logic                oBit;
    logic                oBusy;
    logic                oDone;
    logic [BITWIDTH-1:0] oCnt;

    modport master (
        output iEn, iClr, iLoad, iData,
        input  oBit, oBusy, oDone, oCnt
    );

    modport slave (
        input  iEn, iClr, iLoad, iData,
        output oBit, oBusy, oDone, oCnt
    );
endinterface

// File: rtl/cntwithen.sv
// Free-running wrap-around counter with enable and synchronous clear (clear wins).
// One-cycle update latency; iEn low simply holds the count.
module cntwithen #(
    parameter int BITWIDTH = 8
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iEn,
    input  logic                iClr,
    output logic [BITWIDTH-1:0] oCnt
);

    logic [BITWIDTH-1:0] cnt_q;
    logic [BITWIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (iClr) begin
            cnt_d = '0;
        end else if (iEn) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign oCnt = cnt_q;

endmodule

// File: rtl/unary_gen.sv
// Thermometer-coded unary stream generator: 2^BITWIDTH bits per load, first 'value' bits high.
// Bit valid combinationally each RUN cycle; iEn low freezes the stream, iLoad during RUN is dropped.
module unary_gen
    import unary_gen_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH
) (
    input  logic       iClk,
    input  logic       iRstN,
    unary_gen_if.slave bus
);

    state_e              state_q;
    state_e              state_d;
    logic [BITWIDTH-1:0] value_q;
    logic [BITWIDTH-1:0] value_d;
    logic [BITWIDTH-1:0] cnt;
    logic                load_acc;
    logic                cnt_en;
    logic                cnt_clr;

    always_comb begin
        load_acc = bus.iLoad && !bus.iClr && (state_q == ST_IDLE || state_q == ST_DONE);
        cnt_en   = (state_q == ST_RUN) && bus.iEn;
        cnt_clr  = bus.iClr || load_acc;
    end

    cntwithen #(
        .BITWIDTH (BITWIDTH)
    ) u_period_cnt (
        .iClk  (iClk),
        .iRstN (iRstN),
        .iEn   (cnt_en),
        .iClr  (cnt_clr),
        .oCnt  (cnt)
    );

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        if (load_acc) begin
            value_d = bus.iData;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (load_acc) state_d = ST_RUN;
            end
            ST_RUN: begin
                // The all-ones position is the last emitted bit; the counter wraps to 0 here.
                if (bus.iEn && (&cnt)) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = load_acc ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (bus.iClr) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= ST_IDLE;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
        end
    end

    assign bus.oBusy = (state_q == ST_RUN);
    assign bus.oDone = (state_q == ST_DONE);
    assign bus.oBit  = (state_q == ST_RUN) && (cnt < value_q);
    assign bus.oCnt  = cnt;

endmodule
